// File: rtl/ic_pkg.sv
// rtl/ic_pkg.sv - shared widths, vector type and FSM encoding for the triangle feeder
package ic_pkg;

    localparam int VEC_W = 96;
    localparam int TRI_W = 288;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] y;
        logic [31:0] x;
    } vec3_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Triangle words are packed {v2,v1,v0}; k selects the vertex.
    function automatic vec3_t tri_vertex(input logic [TRI_W-1:0] trig, input logic [1:0] k);
        return trig[k*VEC_W +: VEC_W];
    endfunction

endpackage

// File: rtl/ic_delay_line.sv
// rtl/ic_delay_line.sv - fixed-depth shift register with synchronous clear
module ic_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ic_tri_feeder.sv
// rtl/ic_tri_feeder.sv - issues triangle reads for one ray and aligns sideband with the adder
module ic_tri_feeder
    import ic_pkg::*;
#(
    parameter int ADD_LAT = 3,
    parameter int TRI_AW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [VEC_W-1:0]  ray_orig,
    input  logic [VEC_W-1:0]  ray_dir,
    input  logic [TRI_AW-1:0] ray_tri_base,
    input  logic [TRI_AW-1:0] ray_tri_count,
    output logic              mem_rd_en,
    output logic [TRI_AW-1:0] mem_rd_addr,
    input  logic [TRI_W-1:0]  mem_rd_data,
    output logic [VEC_W-1:0]  v0,
    output logic [VEC_W-1:0]  v1,
    output logic [VEC_W-1:0]  v2,
    output logic [VEC_W-1:0]  orig,
    input  logic              pp_stall,
    output logic              sb_valid,
    output logic [TRI_AW-1:0] sb_tri_id,
    output logic              sb_last,
    output logic [VEC_W-1:0]  sb_dir,
    output logic              done
);

    localparam int SB_W = 1 + TRI_AW + 1 + VEC_W;

    state_t              state_q, state_d;
    logic [TRI_AW-1:0]   idx_q, idx_d;
    logic [TRI_AW:0]     inflight_q, inflight_d;
    logic [TRI_AW-1:0]   base_q, count_q;
    vec3_t               ray_orig_q, dir_q;
    logic                accept;
    logic                last_issue;

    logic                rd_pend_q;
    logic [TRI_AW-1:0]   pend_id_q;
    logic                pend_last_q;
    logic [VEC_W-1:0]    v0_q, v1_q, v2_q, orig_q;
    logic [SB_W-1:0]     sb_stage_q;
    logic [SB_W-1:0]     sb_out;

    assign last_issue  = (idx_q == (count_q - TRI_AW'(1)));
    assign mem_rd_addr = base_q + idx_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ray_ready = 1'b0;
        mem_rd_en = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ray_ready = 1'b1;
                if (ray_valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = (ray_tri_count != '0) ? ST_ISSUE : ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                if (!pp_stall) begin
                    mem_rd_en = 1'b1;
                    idx_d     = idx_q + TRI_AW'(1);
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In-flight spans issue up to the sideband leaving the delay line.
    always_comb begin
        inflight_d = inflight_q;
        case ({mem_rd_en, sb_valid})
            2'b10:   inflight_d = inflight_q + (TRI_AW+1)'(1);
            2'b01:   inflight_d = inflight_q - (TRI_AW+1)'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            inflight_q  <= '0;
            base_q      <= '0;
            count_q     <= '0;
            ray_orig_q  <= '0;
            dir_q       <= '0;
            rd_pend_q   <= 1'b0;
            pend_id_q   <= '0;
            pend_last_q <= 1'b0;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            orig_q      <= '0;
            sb_stage_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inflight_q  <= inflight_d;
            if (accept) begin
                base_q     <= ray_tri_base;
                count_q    <= ray_tri_count;
                ray_orig_q <= ray_orig;
                dir_q      <= ray_dir;
            end
            rd_pend_q   <= mem_rd_en;
            pend_id_q   <= mem_rd_addr;
            pend_last_q <= mem_rd_en & last_issue;
            // Memory data arrives the cycle after the strobe; operands and the
            // first sideband stage load together so they stay aligned.
            if (rd_pend_q) begin
                v0_q   <= tri_vertex(mem_rd_data, 2'd0);
                v1_q   <= tri_vertex(mem_rd_data, 2'd1);
                v2_q   <= tri_vertex(mem_rd_data, 2'd2);
                orig_q <= ray_orig_q;
            end
            sb_stage_q <= rd_pend_q ? {1'b1, pend_id_q, pend_last_q, dir_q} : '0;
        end
    end

    ic_delay_line #(
        .DEPTH (ADD_LAT),
        .WIDTH (SB_W)
    ) u_sb_line (
        .clk_i  (clk),
        .clr_i  (rst),
        .din_i  (sb_stage_q),
        .dout_o (sb_out)
    );

    assign {sb_valid, sb_tri_id, sb_last, sb_dir} = sb_out;
    assign v0   = v0_q;
    assign v1   = v1_q;
    assign v2   = v2_q;
    assign orig = orig_q;

endmodule

// File: tb/tb_ic_tri_feeder.sv
// tb/tb_ic_tri_feeder.sv - directed self-checking bench for ic_tri_feeder
module tb_ic_tri_feeder;

    logic          clk = 1'b0;
    logic          rst;
    logic          ray_valid;
    logic          ray_ready;
    logic [95:0]   ray_orig, ray_dir;
    logic [15:0]   ray_tri_base, ray_tri_count;
    logic          mem_rd_en;
    logic [15:0]   mem_rd_addr;
    logic [287:0]  mem_rd_data = '0;
    logic [95:0]   v0, v1, v2, orig;
    logic          pp_stall;
    logic          sb_valid;
    logic [15:0]   sb_tri_id;
    logic          sb_last;
    logic [95:0]   sb_dir;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          acc_q[$];
    int          rd_cyc_q[$];
    logic [15:0] rd_addr_q[$];
    int          sb_cyc_q[$];
    logic [15:0] sb_id_q[$];
    logic        sb_last_q[$];
    logic [95:0] sb_dir_q[$];
    int          done_q[$];

    localparam logic [95:0] D1 = 96'h3F80_0000_4000_0000_4040_0000;
    localparam logic [95:0] D2 = 96'hBF80_0000_C000_0000_C040_0000;
    localparam logic [95:0] O1 = 96'h4120_0000_4110_0000_4100_0000;

    ic_tri_feeder #(.ADD_LAT(3), .TRI_AW(16)) dut (
        .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_orig(ray_orig), .ray_dir(ray_dir), .ray_tri_base(ray_tri_base),
        .ray_tri_count(ray_tri_count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .v0(v0), .v1(v1), .v2(v2), .orig(orig),
        .pp_stall(pp_stall), .sb_valid(sb_valid), .sb_tri_id(sb_tri_id),
        .sb_last(sb_last), .sb_dir(sb_dir), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [287:0] tri_of(input logic [15:0] a);
        return {16'h2002, a, 16'h2001, a, 16'h2000, a,
                16'h1102, a, 16'h1101, a, 16'h1100, a,
                16'h0002, a, 16'h0001, a, 16'h0000, a};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rd_data <= tri_of(mem_rd_addr);
    end

    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(mem_rd_addr);
        end
        if (sb_valid === 1'b1) begin
            sb_cyc_q.push_back(cyc);
            sb_id_q.push_back(sb_tri_id);
            sb_last_q.push_back(sb_last);
            sb_dir_q.push_back(sb_dir);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (ray_valid === 1'b1 && ray_ready === 1'b1) acc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete();
        sb_cyc_q.delete(); sb_id_q.delete(); sb_last_q.delete();
        sb_dir_q.delete(); done_q.delete();
    endtask

    task automatic start_ray(input logic [15:0] base, input logic [15:0] cnt, input logic [95:0] dir);
        ray_tri_base  = base;
        ray_tri_count = cnt;
        ray_dir       = dir;
        ray_orig      = O1;
        ray_valid     = 1'b1;
        tick();
        ray_valid     = 1'b0;
    endtask

    task automatic check_outputs_idle(input string tag);
        chk({tag, " ray_ready"}, ray_ready, 1);
        chk({tag, " mem_rd_en"}, mem_rd_en, 0);
        chk({tag, " mem_rd_addr"}, mem_rd_addr, 0);
        chk({tag, " sb_valid"}, sb_valid, 0);
        chk({tag, " sb_tri_id"}, sb_tri_id, 0);
        chk({tag, " sb_last"}, sb_last, 0);
        chk({tag, " sb_dir"}, sb_dir, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " v0"}, v0, 0);
        chk({tag, " v2"}, v2, 0);
        chk({tag, " orig"}, orig, 0);
    endtask

    // Read i lands at accept+1+i (+gap once i reaches gi); sideband 5 cycles after; done 1 after last.
    task automatic check_ray(input string tag, input int ai, input int ro, input int di,
                             input logic [15:0] base, input int n, input logic [95:0] dir,
                             input int gi, input int gl);
        int rc;
        logic [15:0] ea;
        rc = 0;
        for (int i = 0; i < n; i++) begin
            rc = acc_q[ai] + 1 + i + ((i >= gi) ? gl : 0);
            ea = base + 16'(i);
            chk($sformatf("%s rd_addr[%0d]", tag, i), rd_addr_q[ro+i], ea);
            chk($sformatf("%s rd_cyc[%0d]", tag, i), rd_cyc_q[ro+i], rc);
            chk($sformatf("%s sb_id[%0d]", tag, i), sb_id_q[ro+i], ea);
            chk($sformatf("%s sb_cyc[%0d]", tag, i), sb_cyc_q[ro+i], rc + 5);
            chk($sformatf("%s sb_last[%0d]", tag, i), sb_last_q[ro+i], (i == n - 1));
            chk($sformatf("%s sb_dir[%0d]", tag, i), sb_dir_q[ro+i], dir);
        end
        chk({tag, " done_cyc"}, done_q[di], rc + 6);
    endtask

    initial begin
        logic [287:0] t;
        rst = 1'b1; ray_valid = 1'b0; pp_stall = 1'b0;
        ray_orig = '0; ray_dir = '0; ray_tri_base = '0; ray_tri_count = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_outputs_idle("reset");

        // base 5, count 3, no stall
        clear_logs();
        start_ray(16'd5, 16'd3, D1);
        repeat (15) tick();
        chk("s1 accepts", acc_q.size(), 1);
        chk("s1 reads", rd_cyc_q.size(), 3);
        chk("s1 sbs", sb_cyc_q.size(), 3);
        chk("s1 dones", done_q.size(), 1);
        check_ray("s1", 0, 0, 0, 16'd5, 3, D1, 99, 0);
        t = tri_of(16'd7);
        chk("s1 v0 hold", v0, t[95:0]);
        chk("s1 v1 hold", v1, t[191:96]);
        chk("s1 v2 hold", v2, t[287:192]);
        chk("s1 orig", orig, O1);

        // count 0
        clear_logs();
        start_ray(16'h0033, 16'd0, D2);
        repeat (8) tick();
        chk("s2 reads", rd_cyc_q.size(), 0);
        chk("s2 sbs", sb_cyc_q.size(), 0);
        chk("s2 dones", done_q.size(), 1);
        chk("s2 done_cyc", done_q[0], acc_q[0] + 1);

        // address wrap
        clear_logs();
        start_ray(16'hFFFE, 16'd4, D2);
        repeat (15) tick();
        chk("s3 reads", rd_cyc_q.size(), 4);
        chk("s3 sbs", sb_cyc_q.size(), 4);
        chk("s3 dones", done_q.size(), 1);
        check_ray("s3", 0, 0, 0, 16'hFFFE, 4, D2, 99, 0);

        // stall for 2 cycles after the 2nd read
        clear_logs();
        start_ray(16'h0020, 16'd4, D1);
        tick();
        tick();
        pp_stall = 1'b1;
        tick();
        tick();
        pp_stall = 1'b0;
        repeat (15) tick();
        chk("s4 reads", rd_cyc_q.size(), 4);
        chk("s4 sbs", sb_cyc_q.size(), 4);
        chk("s4 dones", done_q.size(), 1);
        check_ray("s4", 0, 0, 0, 16'h0020, 4, D1, 2, 2);

        // reset after 2 of 6 reads
        clear_logs();
        start_ray(16'h0040, 16'd6, D1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_idle("s5");
        repeat (15) tick();
        chk("s5 reads", rd_cyc_q.size(), 2);
        chk("s5 sbs", sb_cyc_q.size(), 0);
        chk("s5 dones", done_q.size(), 0);

        // back-to-back rays with ray_valid held
        clear_logs();
        ray_tri_base = 16'h0100; ray_tri_count = 16'd2; ray_dir = D1; ray_orig = O1;
        ray_valid = 1'b1;
        tick();
        ray_tri_base = 16'h0200; ray_tri_count = 16'd1; ray_dir = D2;
        for (int k = 0; k < 40 && acc_q.size() < 2; k++) tick();
        ray_valid = 1'b0;
        repeat (12) tick();
        chk("s6 accepts", acc_q.size(), 2);
        chk("s6 reads", rd_cyc_q.size(), 3);
        chk("s6 dones", done_q.size(), 2);
        chk("s6 accept2_cyc", acc_q[1], done_q[0] + 1);
        check_ray("s6r1", 0, 0, 0, 16'h0100, 2, D1, 99, 0);
        check_ray("s6r2", 1, 2, 1, 16'h0200, 1, D2, 99, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic_tri_feeder.md
IC_TRI_FEEDER -- requirements
Module: ic_tri_feeder

Interface
REQ-001 Parameter ADD_LAT, default 3: the preprocess adder latency in cycles; the sideband delay equals this value.
REQ-002 Parameter TRI_AW, default 16: triangle memory address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ray_valid  input  1  ray request present.
REQ-006 ray_ready  output  1  feeder idle and able to accept a ray.
REQ-007 ray_orig  input  96  ray origin {z,y,x}, fp32 each.
REQ-008 ray_dir  input  96  ray direction {z,y,x}, fp32 each.
REQ-009 ray_tri_base  input  TRI_AW  first triangle index.
REQ-010 ray_tri_count  input  TRI_AW  number of triangles to test.
REQ-011 mem_rd_en  output  1  triangle memory read strobe.
REQ-012 mem_rd_addr  output  TRI_AW  triangle index to read.
REQ-013 mem_rd_data  input  288  {v2,v1,v0}, 96 bits each; valid exactly 1 cycle after mem_rd_en.
REQ-014 v0, v1, v2, orig  output  96 each  registered operands to the preprocess stage.
REQ-015 pp_stall  input  1  downstream asks the feeder to stop issuing new reads.
REQ-016 sb_valid  output  1  preprocess results valid this cycle.
REQ-017 sb_tri_id  output  TRI_AW  index of the triangle whose results are valid.
REQ-018 sb_last  output  1  final triangle of the current ray.
REQ-019 sb_dir  output  96  ray direction aligned with the results.
REQ-020 done  output  1  one-cycle pulse when the ray is fully drained.

Function
REQ-021 FSM states: IDLE, ISSUE, DRAIN; ray_ready=1 only in IDLE.
REQ-022 IDLE: ray_valid=1 latches orig, dir, base and count; next state is ISSUE if count!=0, else DRAIN.
REQ-023 ISSUE, pp_stall=0: assert mem_rd_en with mem_rd_addr=(base+idx) mod 2^TRI_AW, then increment idx; after issuing idx==count-1, go to DRAIN.
REQ-024 ISSUE, pp_stall=1: mem_rd_en=0, idx holds; reads already issued continue through the pipeline (no stall of in-flight data).
REQ-025 Read issued in cycle T: v0/v1/v2 load from mem_rd_data at the end of T+1 and are visible from T+2, with orig = latched ray origin.
REQ-026 v0/v1/v2/orig hold their last value when no new triangle is loaded.
REQ-027 Sideband (valid, tri_id, last, dir) enters the delay line with the operand load and appears ADD_LAT cycles later: sb_valid=1 in cycle T+2+ADD_LAT.
REQ-028 sb_tri_id equals the mem_rd_addr that was used; sb_last=1 only for idx==count-1.
REQ-029 DRAIN: wait until the in-flight count (issued minus sb_valid) is 0, then pulse done for 1 cycle and return to IDLE.
REQ-030 count=0: no reads and no sb_valid; done pulses 1 cycle after acceptance.
REQ-031 A new ray is accepted no earlier than the cycle after done.
REQ-032 Peak throughput is 1 triangle per cycle with no bubbles while pp_stall=0.

Reset
REQ-033 Reset drives state=IDLE, idx=0, in-flight=0, the delay line cleared, and every output to 0 (ray_ready=1 once reset is released).
REQ-034 Reset mid-ray discards all in-flight triangles; no done and no sb_valid follow it.

Structure
REQ-035 Package ic_pkg holds VEC_W=96, TRI_W=288, the fp32 vector typedef and the FSM state enum.
REQ-036 Sub-module ic_delay_line: a parameterised-depth, parameterised-width shift register with synchronous clear, used for the sideband.

Verification
REQ-037 base=5, count=3, no stall: reads at addresses 5,6,7 in consecutive cycles; sb_tri_id=5,6,7 in consecutive cycles starting at T+2+ADD_LAT; sb_last only on 7; done 1 cycle after the last sb_valid.
REQ-038 count=0: done pulses 1 cycle after acceptance; mem_rd_en and sb_valid never assert.
REQ-039 base=0xFFFE, count=4: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-040 count=4, pp_stall high for 2 cycles after the 2nd read: exactly 4 reads; sb_valid shows a 2-cycle gap; ids stay in order.
REQ-041 rst asserted after 2 of 6 reads: all outputs 0 and ray_ready=1 after reset is released; no done and no sb_valid follow.
REQ-042 Back-to-back rays, ray_valid held high: the 2nd ray is accepted the cycle after done; its sb_dir matches its own ray_dir.
